// File: rtl/hill_cipher_decrypt.sv
// Hill cipher (3x3, mod 26) decryptor: derives the inverse key on-chip from the
// plaintext key, then decrypts 3-letter ciphertext blocks into uppercase text.
module hill_cipher_decrypt #(
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_SIZE = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] key_data,
  input  logic [3:0]            key_addr,
  input  logic                  key_wen,
  input  logic                  key_load,
  output logic                  key_ready,
  output logic                  key_invalid,
  input  logic [DATA_WIDTH-1:0] text_in,
  input  logic [1:0]            text_in_addr,
  input  logic                  text_in_wen,
  input  logic                  start,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] text_out,
  output logic                  text_out_valid,
  output logic                  done
);

  localparam int NKEY = BLOCK_SIZE * BLOCK_SIZE;

  // COF: cofactors, DET: determinant, INV: det^-1, MUL: adjugate scaling,
  // DEC: row MACs, OUT: stream plaintext
  typedef enum logic [2:0] {S_IDLE, S_COF, S_DET, S_INV, S_MUL, S_DEC, S_OUT} state_t;

  state_t                          state_q, state_d;
  logic [3:0]                      cnt_q, cnt_d;
  logic                            key_ready_q, key_ready_d;
  logic                            key_invalid_q, key_invalid_d;
  logic [DATA_WIDTH-1:0]           text_out_q, text_out_d;
  logic                            text_out_valid_q, text_out_valid_d;
  logic                            done_q, done_d;
  logic [4:0]                      det_q, det_d;
  logic [4:0]                      detinv_q, detinv_d;
  logic [15:0]                     acc_q, acc_d;

  logic [NKEY-1:0][DATA_WIDTH-1:0] key_q, key_d;
  logic [NKEY-1:0][4:0]            cof_q, cof_d;
  logic [NKEY-1:0][4:0]            inv_q, inv_d;
  logic [BLOCK_SIZE-1:0][4:0]      ct_q, ct_d;
  logic [BLOCK_SIZE-1:0][4:0]      pt_q, pt_d;

  logic [NKEY-1:0][4:0]            kr;
  logic [1:0]                      row, col, r1, r2, c1, c2;
  logic [10:0]                     ad, bc, minor_sum, det_sum;
  logic [4:0]                      minor, minor_neg, cof_val;
  logic [5:0]                      inv_lut;
  logic                            key_wr_ok;

  function automatic logic [3:0] idx(input logic [1:0] r, input logic [1:0] c);
    return 4'(r) * 4'd3 + 4'(c);
  endfunction

  function automatic logic [4:0] char_num(input logic [DATA_WIDTH-1:0] ch);
    logic [DATA_WIDTH-1:0] t;
    t = '0;
    if (ch >= DATA_WIDTH'(65) && ch <= DATA_WIDTH'(90))
      t = ch - DATA_WIDTH'(65);
    else if (ch >= DATA_WIDTH'(97) && ch <= DATA_WIDTH'(122))
      t = ch - DATA_WIDTH'(97);
    return 5'(t);
  endfunction

  // {valid, inverse}; only units of Z/26 have an inverse
  function automatic logic [5:0] inv26(input logic [4:0] d);
    case (d)
      5'd1:    return {1'b1, 5'd1};
      5'd3:    return {1'b1, 5'd9};
      5'd5:    return {1'b1, 5'd21};
      5'd7:    return {1'b1, 5'd15};
      5'd9:    return {1'b1, 5'd3};
      5'd11:   return {1'b1, 5'd19};
      5'd15:   return {1'b1, 5'd7};
      5'd17:   return {1'b1, 5'd23};
      5'd19:   return {1'b1, 5'd11};
      5'd21:   return {1'b1, 5'd5};
      5'd23:   return {1'b1, 5'd17};
      5'd25:   return {1'b1, 5'd25};
      default: return 6'd0;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < NKEY; i++)
      kr[i] = 5'(key_q[i] % DATA_WIDTH'(26));
  end

  always_comb begin
    row = 2'd0;
    col = 2'd0;
    case (cnt_q)
      4'd1: col = 2'd1;
      4'd2: col = 2'd2;
      4'd3: row = 2'd1;
      4'd4: begin row = 2'd1; col = 2'd1; end
      4'd5: begin row = 2'd1; col = 2'd2; end
      4'd6: row = 2'd2;
      4'd7: begin row = 2'd2; col = 2'd1; end
      4'd8: begin row = 2'd2; col = 2'd2; end
      default: ;
    endcase
    r1 = (row == 2'd0) ? 2'd1 : 2'd0;
    r2 = (row == 2'd2) ? 2'd1 : 2'd2;
    c1 = (col == 2'd0) ? 2'd1 : 2'd0;
    c2 = (col == 2'd2) ? 2'd1 : 2'd2;
    ad = 11'(kr[idx(r1, c1)]) * 11'(kr[idx(r2, c2)]);
    bc = 11'(kr[idx(r1, c2)]) * 11'(kr[idx(r2, c1)]);
    // +676 (26*26) keeps the difference non-negative without changing it mod 26
    minor_sum = ad + 11'd676 - bc;
    minor     = 5'(minor_sum % 11'd26);
    minor_neg = 5'((5'd26 - minor) % 5'd26);
    cof_val   = (row[0] ^ col[0]) ? minor_neg : minor;
    det_sum   = 11'(kr[0]) * 11'(cof_q[0]) + 11'(kr[1]) * 11'(cof_q[1])
              + 11'(kr[2]) * 11'(cof_q[2]);
    inv_lut   = inv26(det_q);
  end

  assign key_wr_ok = key_wen && (key_addr < 4'(NKEY));

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    key_ready_d      = key_ready_q;
    key_invalid_d    = key_invalid_q;
    text_out_d       = text_out_q;
    text_out_valid_d = 1'b0;
    done_d           = 1'b0;
    det_d            = det_q;
    detinv_d         = detinv_q;
    acc_d            = acc_q;
    key_d            = key_q;
    cof_d            = cof_q;
    inv_d            = inv_q;
    ct_d             = ct_q;
    pt_d             = pt_q;

    case (state_q)
      S_IDLE: begin
        if (key_wr_ok) begin
          key_d[key_addr] = key_data;
          key_ready_d     = 1'b0;
          key_invalid_d   = 1'b0;
        end
        if (text_in_wen && (text_in_addr < 2'(BLOCK_SIZE)))
          ct_d[text_in_addr] = char_num(text_in);
        if (key_load) begin
          state_d       = S_COF;
          cnt_d         = 4'd0;
          key_ready_d   = 1'b0;
          key_invalid_d = 1'b0;
        end else if (start && key_ready_q && !key_wr_ok) begin
          state_d = S_DEC;
          cnt_d   = 4'd0;
          acc_d   = 16'd0;
        end
      end
      S_COF: begin
        cof_d[cnt_q] = cof_val;
        if (cnt_q == 4'd8) begin
          state_d = S_DET;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DET: begin
        det_d   = 5'(det_sum % 11'd26);
        state_d = S_INV;
      end
      S_INV: begin
        if (inv_lut[5]) begin
          detinv_d = inv_lut[4:0];
          state_d  = S_MUL;
          cnt_d    = 4'd0;
        end else begin
          key_invalid_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_MUL: begin
        // transpose: inverse row i / col j takes cofactor at (j, i)
        inv_d[cnt_q] = 5'((10'(detinv_q) * 10'(cof_q[idx(col, row)])) % 10'd26);
        if (cnt_q == 4'd8) begin
          key_ready_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DEC: begin
        if (cnt_q[1:0] == 2'd3) begin
          pt_d[cnt_q[3:2]] = 5'(acc_q % 16'd26);
          acc_d            = 16'd0;
        end else begin
          acc_d = acc_q + 16'(inv_q[idx(cnt_q[3:2], cnt_q[1:0])]) * 16'(ct_q[cnt_q[1:0]]);
        end
        if (cnt_q == 4'd11) begin
          state_d = S_OUT;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_OUT: begin
        if (cnt_q == 4'd3) begin
          state_d = S_IDLE;
        end else begin
          text_out_d       = DATA_WIDTH'(pt_q[cnt_q[1:0]]) + DATA_WIDTH'(65);
          text_out_valid_d = 1'b1;
          done_d           = (cnt_q == 4'd2);
          cnt_d            = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      cnt_q            <= 4'd0;
      key_ready_q      <= 1'b0;
      key_invalid_q    <= 1'b0;
      text_out_q       <= '0;
      text_out_valid_q <= 1'b0;
      done_q           <= 1'b0;
      det_q            <= 5'd0;
      detinv_q         <= 5'd0;
      acc_q            <= 16'd0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      key_ready_q      <= key_ready_d;
      key_invalid_q    <= key_invalid_d;
      text_out_q       <= text_out_d;
      text_out_valid_q <= text_out_valid_d;
      done_q           <= done_d;
      det_q            <= det_d;
      detinv_q         <= detinv_d;
      acc_q            <= acc_d;
    end
  end

  always_ff @(posedge clk) begin
    key_q <= key_d;
    cof_q <= cof_d;
    inv_q <= inv_d;
    ct_q  <= ct_d;
    pt_q  <= pt_d;
  end

  assign key_ready      = key_ready_q;
  assign key_invalid    = key_invalid_q;
  assign busy           = (state_q != S_IDLE);
  assign text_out       = text_out_q;
  assign text_out_valid = text_out_valid_q;
  assign done           = done_q;

endmodule

// File: tb/tb_hill_cipher_decrypt.sv
// Bench for hill_cipher_decrypt: vector table, corner sequences, and random keys
// and blocks checked against a closed-form matrix-inverse reference model.
module tb_hill_cipher_decrypt;

  typedef logic [8:0][7:0] key_t;
  typedef logic [2:0][7:0] blk_t;
  typedef struct {
    key_t key;
    blk_t ct;
    blk_t exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key_data;
  logic [3:0] key_addr;
  logic       key_wen, key_load, key_ready, key_invalid;
  logic [7:0] text_in;
  logic [1:0] text_in_addr;
  logic       text_in_wen, start, busy;
  logic [7:0] text_out;
  logic       text_out_valid, done;

  int total = 0;
  int bad   = 0;

  hill_cipher_decrypt dut (
    .clk(clk), .rst(rst),
    .key_data(key_data), .key_addr(key_addr), .key_wen(key_wen),
    .key_load(key_load), .key_ready(key_ready), .key_invalid(key_invalid),
    .text_in(text_in), .text_in_addr(text_in_addr), .text_in_wen(text_in_wen),
    .start(start), .busy(busy), .text_out(text_out),
    .text_out_valid(text_out_valid), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int tb_map(input logic [7:0] ch);
    if (ch >= 8'd65 && ch <= 8'd90) return int'(ch) - 65;
    if (ch >= 8'd97 && ch <= 8'd122) return int'(ch) - 97;
    return 0;
  endfunction

  // Inverse via closed-form adjugate and brute-force search for det^-1 mod 26
  function automatic void model_inv(input key_t k, output logic [8:0][4:0] inv, output bit ok);
    int m[9];
    int adj[9];
    int det, dinv;
    for (int i = 0; i < 9; i++) m[i] = int'(k[i]) % 26;
    det = m[0]*(m[4]*m[8]-m[5]*m[7]) - m[1]*(m[3]*m[8]-m[5]*m[6]) + m[2]*(m[3]*m[7]-m[4]*m[6]);
    det = ((det % 26) + 26) % 26;
    dinv = -1;
    for (int x = 1; x < 26; x++) if ((det * x) % 26 == 1) dinv = x;
    adj[0] = m[4]*m[8]-m[5]*m[7];    adj[1] = -(m[1]*m[8]-m[2]*m[7]); adj[2] = m[1]*m[5]-m[2]*m[4];
    adj[3] = -(m[3]*m[8]-m[5]*m[6]); adj[4] = m[0]*m[8]-m[2]*m[6];    adj[5] = -(m[0]*m[5]-m[2]*m[3]);
    adj[6] = m[3]*m[7]-m[4]*m[6];    adj[7] = -(m[0]*m[7]-m[1]*m[6]); adj[8] = m[0]*m[4]-m[1]*m[3];
    ok = (dinv >= 0);
    for (int i = 0; i < 9; i++)
      inv[i] = ok ? 5'((((dinv * adj[i]) % 26) + 26) % 26) : 5'd0;
  endfunction

  function automatic blk_t model_dec(input logic [8:0][4:0] inv, input blk_t c);
    blk_t r;
    int s;
    for (int i = 0; i < 3; i++) begin
      s = 0;
      for (int j = 0; j < 3; j++) s += int'(inv[i*3+j]) * tb_map(c[j]);
      r[i] = 8'((s % 26) + 65);
    end
    return r;
  endfunction

  function automatic blk_t str3(input string s);
    blk_t r;
    for (int i = 0; i < 3; i++) r[i] = s[i];
    return r;
  endfunction

  task automatic write_key(input key_t k);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      key_wen = 1'b1; key_addr = 4'(i); key_data = k[i];
    end
    @(negedge clk);
    key_wen = 1'b0;
  endtask

  task automatic write_ct(input blk_t c);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      text_in_wen = 1'b1; text_in_addr = 2'(i); text_in = c[i];
    end
    @(negedge clk);
    text_in_wen = 1'b0;
  endtask

  task automatic load_key(input bit also_start, output int rc, output int ic, output int vc);
    @(negedge clk);
    key_load = 1'b1; start = also_start;
    @(negedge clk);
    key_load = 1'b0; start = 1'b0;
    rc = -1; ic = -1; vc = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (key_ready && rc < 0) rc = n;
      if (key_invalid && ic < 0) ic = n;
      if (text_out_valid) vc++;
      if (!busy) break;
    end
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (text_out_valid) vc++;
    end
  endtask

  task automatic run_dec(input bit poke, output blk_t o, output int first, output int done_c,
                         output int nv, output int end_c);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    o = '0; first = -1; done_c = -1; nv = 0; end_c = -1;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      if (poke && n == 2) begin
        key_wen = 1'b1; key_addr = 4'd0; key_data = 8'd25; start = 1'b1;
      end
      if (n == 3) begin
        key_wen = 1'b0; start = 1'b0;
      end
      if (text_out_valid) begin
        if (nv < 3) o[nv] = text_out;
        if (first < 0) first = n;
        nv++;
      end
      if (done && done_c < 0) done_c = n;
      if (!busy && end_c < 0) end_c = n;
    end
  endtask

  task automatic dec_check(input string nm, input bit poke, input blk_t exp);
    blk_t o;
    int f, d, nv, e;
    run_dec(poke, o, f, d, nv, e);
    chk({nm, " first_cycle"}, f, 13);
    chk({nm, " done_cycle"}, d, 15);
    chk({nm, " nvalid"}, nv, 3);
    chk({nm, " idle_cycle"}, e, 16);
    for (int i = 0; i < 3; i++) chk($sformatf("%s ch%0d", nm, i), int'(o[i]), int'(exp[i]));
  endtask

  vec_t vecs[5];
  key_t kg, kid, kd2, kr;
  logic [8:0][4:0] minv;
  bit   mok;
  blk_t o, c, mexp;
  int   rc, ic, vc, f, d, nv, e;

  initial begin
    kg  = {8'd15, 8'd17, 8'd20, 8'd10, 8'd16, 8'd13, 8'd1, 8'd24, 8'd6};
    kid = {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    kd2 = {8'd2, 8'd0, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0, 8'd2};
    vecs[0] = '{kg,  str3("POH"), str3("ACT")};
    vecs[1] = '{kg,  str3("poh"), str3("ACT")};
    vecs[2] = '{kg,  str3("P?H"), str3("IUH")};
    vecs[3] = '{kid, str3("XYZ"), str3("XYZ")};
    vecs[4] = '{kid, str3("a[z"), str3("AAZ")};

    rst = 1'b1; key_data = '0; key_addr = '0; key_wen = 0; key_load = 0;
    text_in = '0; text_in_addr = '0; text_in_wen = 0; start = 0;
    repeat (3) @(negedge clk);
    chk("rst key_ready", key_ready, 0);
    chk("rst key_invalid", key_invalid, 0);
    chk("rst busy", busy, 0);
    chk("rst valid", text_out_valid, 0);
    chk("rst done", done, 0);
    chk("rst text_out", text_out, 0);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      if (v == 0 || vecs[v].key != vecs[v-1].key) begin
        write_key(vecs[v].key);
        load_key(1'b0, rc, ic, vc);
        chk($sformatf("vec%0d ready_cycle", v), rc, 20);
        chk($sformatf("vec%0d invalid", v), ic, -1);
      end
      write_ct(vecs[v].ct);
      model_inv(vecs[v].key, minv, mok);
      mexp = model_dec(minv, vecs[v].ct);
      run_dec(1'b0, o, f, d, nv, e);
      chk($sformatf("vec%0d first_cycle", v), f, 13);
      chk($sformatf("vec%0d done_cycle", v), d, 15);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("vec%0d ch%0d", v, i), int'(o[i]), int'(vecs[v].exp[i]));
        chk($sformatf("vec%0d model ch%0d", v, i), int'(o[i]), int'(mexp[i]));
      end
    end

    // identity still loaded: out-of-range writes are ignored
    write_ct(str3("XYZ"));
    @(negedge clk); text_in_wen = 1; text_in_addr = 2'd3; text_in = "A";
    @(negedge clk); text_in_wen = 0; key_wen = 1; key_addr = 4'd9; key_data = 8'd5;
    @(negedge clk); key_wen = 0;
    chk("addr9 keeps ready", key_ready, 1);
    dec_check("ident XYZ", 1'b0, str3("XYZ"));
    @(negedge clk); key_wen = 1; key_addr = 4'd4; key_data = 8'd1;
    @(negedge clk); key_wen = 0;
    chk("key_wen clears ready", key_ready, 0);
    run_dec(1'b0, o, f, d, nv, e);
    chk("start w/o key nvalid", nv, 0);
    chk("start w/o key busy", e, 1);

    // key_load wins over simultaneous start
    write_key(kg);
    write_ct(str3("POH"));
    load_key(1'b1, rc, ic, vc);
    chk("load+start ready_cycle", rc, 20);
    chk("load+start no output", vc, 0);

    dec_check("dec poke", 1'b1, str3("ACT"));
    chk("poke keeps ready", key_ready, 1);
    dec_check("after poke", 1'b0, str3("ACT"));

    // reset after the second output character
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    nv = 0;
    for (int n = 1; n <= 25 && nv < 2; n++) begin
      @(negedge clk);
      if (text_out_valid) nv++;
    end
    chk("pre-reset valids", nv, 2);
    #1 rst = 1'b1;
    #1;
    chk("midrst valid", text_out_valid, 0);
    chk("midrst done", done, 0);
    chk("midrst busy", busy, 0);
    chk("midrst key_ready", key_ready, 0);
    @(negedge clk); rst = 1'b0;
    vc = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (text_out_valid) vc++;
    end
    chk("no third char", vc, 0);
    run_dec(1'b0, o, f, d, nv, e);
    chk("post-reset start ignored", nv, 0);

    write_key(kd2);
    load_key(1'b0, rc, ic, vc);
    chk("diag2 invalid_cycle", ic, 11);
    chk("diag2 ready", rc, -1);
    run_dec(1'b0, o, f, d, nv, e);
    chk("diag2 start nvalid", nv, 0);

    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 9; i++) kr[i] = 8'($urandom_range(0, 255));
      model_inv(kr, minv, mok);
      write_key(kr);
      load_key(1'b0, rc, ic, vc);
      chk($sformatf("rnd%0d ready_cycle", t), rc, mok ? 20 : -1);
      chk($sformatf("rnd%0d invalid_cycle", t), ic, mok ? -1 : 11);
      if (mok) begin
        for (int b = 0; b < 2; b++) begin
          for (int i = 0; i < 3; i++) begin
            case ($urandom_range(0, 3))
              0, 1:    c[i] = 8'(65 + $urandom_range(0, 25));
              2:       c[i] = 8'(97 + $urandom_range(0, 25));
              default: c[i] = 8'($urandom_range(0, 255));
            endcase
          end
          write_ct(c);
          dec_check($sformatf("rnd%0d.%0d", t, b), 1'b0, model_dec(minv, c));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
